// File: rtl/tx_underrun_rpt_pkg.sv
// Shared types and constants for the TX underrun status reporter.
package tx_underrun_rpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_TS_LO,
    ST_TS_HI,
    ST_CNT,
    ST_DONE
  } rpt_state_e;

  localparam logic [3:0]  PKT_TAG_DEFAULT = 4'hA;
  localparam int unsigned TS_WORDS        = 2;
  localparam logic [15:0] SAT_COUNT       = 16'hFFFF;

  // Value of W1: number of words that follow it in the packet.
  function automatic logic [15:0] w1_words(input int unsigned num_chan, input bit with_ts);
    return with_ts ? 16'(num_chan + TS_WORDS) : 16'(num_chan);
  endfunction

endpackage

// File: rtl/tx_underrun_reporter_if.sv
// RX in-band write handshake shared with the command reader.
interface tx_underrun_reporter_if;

  logic [15:0] rx_databus;
  logic        rx_WR;
  logic        rx_WR_done;
  logic        rx_WR_enabled;

  modport master (
    output rx_databus,
    output rx_WR,
    output rx_WR_done,
    input  rx_WR_enabled
  );

  modport slave (
    input  rx_databus,
    input  rx_WR,
    input  rx_WR_done,
    output rx_WR_enabled
  );

endinterface

// File: rtl/underrun_edge_counter.sv
// Per-channel underrun edge detector with 16-bit saturating counter and pending flag.
module underrun_edge_counter
  import tx_underrun_rpt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        underrun,
  input  logic        clear,
  input  logic        take,
  output logic [15:0] count,
  output logic        pend
);

  logic underrun_q;
  logic underrun_q2;
  logic rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q  <= 1'b0;
      underrun_q2 <= 1'b0;
    end else begin
      underrun_q  <= underrun;
      underrun_q2 <= underrun_q;
    end
  end

  assign rise = underrun_q & ~underrun_q2;

  // A rising edge coincident with clear survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
      pend  <= 1'b0;
    end else if (clear) begin
      count <= rise ? 16'd1 : 16'd0;
      pend  <= rise;
    end else begin
      if (rise && (count != SAT_COUNT)) begin
        count <= count + 16'd1;
      end
      if (rise) begin
        pend <= 1'b1;
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_underrun_reporter.sv
// Counts TX underruns per channel and emits rate-limited status packets on the RX in-band path.
// Optional timestamp words: define TX_UNDERRUN_RPT_TIMESTAMP_EN.
module tx_underrun_reporter
  import tx_underrun_rpt_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned HOLDOFF  = 1024,
  parameter logic [3:0]  PKT_TAG  = PKT_TAG_DEFAULT
) (
  input  logic                     txclk,
  input  logic                     reset,
  input  logic [NUM_CHAN-1:0]      tx_underrun,
  input  logic                     clear_status,
  input  logic                     report_enable,
  input  logic [31:0]              timestamp_clock,
  tx_underrun_reporter_if.master   rx,
  output logic [16*NUM_CHAN-1:0]   underrun_count,
  output logic                     busy
);

  localparam int unsigned IDX_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
  localparam logic [15:0] W1_WORD = w1_words(NUM_CHAN, 1'b1);
`else
  localparam logic [15:0] W1_WORD = w1_words(NUM_CHAN, 1'b0);
`endif

  rpt_state_e        state;
  rpt_state_e        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              take;
  logic              load;
  logic              start;
  logic              en;
  logic [15:0]       word_nxt;
  logic [15:0]       databus_q;
  logic              word_valid;
  logic              done_q;
  logic [HOLD_W-1:0] hold;
  logic [NUM_CHAN-1:0] pend;
  logic [15:0]       live_cnt [NUM_CHAN];
  logic [15:0]       snap_cnt [NUM_CHAN];
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
  logic [31:0]       snap_ts;
`else
  logic              unused_ts;
  assign unused_ts = ^timestamp_clock;
`endif

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    underrun_edge_counter u_cnt (
      .clk      (txclk),
      .rst      (reset),
      .underrun (tx_underrun[k]),
      .clear    (clear_status),
      .take     (take),
      .count    (live_cnt[k]),
      .pend     (pend[k])
    );
    assign underrun_count[16*k +: 16] = live_cnt[k];
  end

  assign en    = rx.rx_WR_enabled;
  assign start = (|pend) && report_enable && en && (hold == '0);

  // Next state; word_nxt is the value rx_databus takes when the FSM moves to a new word.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    take      = 1'b0;
    load      = 1'b0;
    word_nxt  = databus_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_W0;
          take      = 1'b1;
          load      = 1'b1;
          word_nxt  = {PKT_TAG, 10'b0, 2'(pend)};
        end
      end
      ST_W0: begin
        if (en) begin
          state_nxt = ST_W1;
          load      = 1'b1;
          word_nxt  = W1_WORD;
        end
      end
      ST_W1: begin
        if (en) begin
          load = 1'b1;
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
          state_nxt = ST_TS_LO;
          word_nxt  = snap_ts[15:0];
`else
          state_nxt = ST_CNT;
          idx_nxt   = '0;
          word_nxt  = snap_cnt[0];
`endif
        end
      end
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
      ST_TS_LO: begin
        if (en) begin
          state_nxt = ST_TS_HI;
          load      = 1'b1;
          word_nxt  = snap_ts[31:16];
        end
      end
      ST_TS_HI: begin
        if (en) begin
          state_nxt = ST_CNT;
          idx_nxt   = '0;
          load      = 1'b1;
          word_nxt  = snap_cnt[0];
        end
      end
`endif
      ST_CNT: begin
        if (en) begin
          if (idx == IDX_W'(NUM_CHAN - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt  = idx + IDX_W'(1);
            load     = 1'b1;
            word_nxt = snap_cnt[idx_nxt];
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      databus_q  <= 16'd0;
      word_valid <= 1'b0;
      done_q     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      if (load) begin
        databus_q <= word_nxt;
      end
      word_valid <= state_nxt inside {ST_W0, ST_W1, ST_TS_LO, ST_TS_HI, ST_CNT};
      done_q     <= (state_nxt == ST_DONE);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Holdoff reloads in DONE; W0 itself carries the pending snapshot.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      hold     <= '0;
      snap_cnt <= '{default: 16'd0};
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
      snap_ts  <= 32'd0;
`endif
    end else begin
      if (state == ST_DONE) begin
        hold <= HOLD_W'(HOLDOFF);
      end else if (hold != '0) begin
        hold <= hold - HOLD_W'(1);
      end
      if (take) begin
        snap_cnt <= live_cnt;
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
        snap_ts  <= timestamp_clock;
`endif
      end
    end
  end

  assign rx.rx_databus = databus_q;
  assign rx.rx_WR      = word_valid & en;
  assign rx.rx_WR_done = done_q;

endmodule

// File: tb/tb_tx_underrun_reporter.sv
// Scoreboard bench for tx_underrun_reporter (HOLDOFF shortened to 16 cycles).
module tb_tx_underrun_reporter;

  localparam int unsigned NCH = 2;
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
  localparam logic [15:0] W1E = 16'd4;
  localparam int          TS_HI_POS = 3;
`else
  localparam logic [15:0] W1E = 16'd2;
  localparam int          TS_HI_POS = 2;
`endif

  logic            txclk;
  logic            reset;
  logic [NCH-1:0]  tx_underrun;
  logic            clear_status;
  logic            report_enable;
  logic [31:0]     timestamp_clock;
  logic [16*NCH-1:0] underrun_count;
  logic            busy;

  tx_underrun_reporter_if rx_if ();

  tx_underrun_reporter #(.NUM_CHAN(NCH), .HOLDOFF(16), .PKT_TAG(4'hA)) dut (
    .txclk           (txclk),
    .reset           (reset),
    .tx_underrun     (tx_underrun),
    .clear_status    (clear_status),
    .report_enable   (report_enable),
    .timestamp_clock (timestamp_clock),
    .rx              (rx_if),
    .underrun_count  (underrun_count),
    .busy            (busy)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_w;

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Output monitor: every accepted word is checked against the scoreboard.
  always @(negedge txclk) begin
    if (rx_if.rx_WR_done === 1'b1) begin
      done_cnt++;
      total++;
      if (rx_if.rx_WR !== 1'b0) begin
        bad++;
        $display("FAIL done_with_wr: rx_WR=%b required 0", rx_if.rx_WR);
      end
    end
    if (rx_if.rx_WR === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %h required no word", rx_if.rx_databus);
      end else begin
        exp_w = sb.pop_front();
        if (rx_if.rx_databus !== exp_w) begin
          bad++;
          $display("FAIL word: got %h required %h", rx_if.rx_databus, exp_w);
        end
      end
    end
  end

  task automatic push_pkt(input logic [1:0] p, input logic [15:0] c0, input logic [15:0] c1,
                          input logic [31:0] ts);
    sb.push_back({4'hA, 10'b0, p});
    sb.push_back(W1E);
`ifdef TX_UNDERRUN_RPT_TIMESTAMP_EN
    sb.push_back(ts[15:0]);
    sb.push_back(ts[31:16]);
`endif
    sb.push_back(c0);
    sb.push_back(c1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge txclk);
    #1;
  endtask

  task automatic edge_pulse(input logic ch);
    @(posedge txclk);
    #1 tx_underrun[ch] = 1'b1;
    @(posedge txclk);
    #1 tx_underrun[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < limit) begin
      @(negedge txclk);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL drain: %0d words left after %0d cycles, required 0", sb.size(), n);
    end
  endtask

  task automatic test_reset();
    tick(3);
    reset = 1'b0;
    @(negedge txclk);
    total++; if (rx_if.rx_WR !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b required 0", rx_if.rx_WR); end
    total++; if (rx_if.rx_WR_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", rx_if.rx_WR_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (rx_if.rx_databus !== 16'h0) begin bad++; $display("FAIL reset_data: got %h required 0000", rx_if.rx_databus); end
    total++; if (underrun_count !== '0) begin bad++; $display("FAIL reset_count: got %h required 0", underrun_count); end
  endtask

  task automatic test_single_edge();
    int lat = -1;
    int d0 = done_cnt;
    timestamp_clock = 32'h0001_0203;
    push_pkt(2'b01, 16'd1, 16'd0, timestamp_clock);
    @(posedge txclk);
    #1 tx_underrun[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge txclk);
      if (rx_if.rx_WR === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++; if (lat != 3) begin bad++; $display("FAIL latency: got %0d required 3", lat); end
    wait_drain(100);
    @(posedge txclk);
    #1 tx_underrun[0] = 1'b0;
    @(negedge txclk);
    total++; if (underrun_count[15:0] !== 16'd1) begin bad++; $display("FAIL single_count: got %h required 0001", underrun_count[15:0]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d required 1", done_cnt - d0); end
    tick(20);
  endtask

  task automatic test_stall();
    bit found = 0;
    int d0 = done_cnt;
    timestamp_clock = 32'hDEAD_BEEF;
    push_pkt(2'b01, 16'd2, 16'd0, timestamp_clock);
    edge_pulse(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge txclk);
      if (rx_if.rx_WR === 1'b1 && rx_if.rx_databus === W1E) begin
        found = 1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL stall_w1: W1 not seen, required %h", W1E); end
    @(posedge txclk);
    #1 rx_if.rx_WR_enabled = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge txclk);
      total++;
      if (rx_if.rx_WR !== 1'b0 || sb.size() == 0 || rx_if.rx_databus !== sb[0]) begin
        bad++;
        $display("FAIL stall_hold: rx_WR=%b data=%h required rx_WR=0 data=next word", rx_if.rx_WR, rx_if.rx_databus);
      end
    end
    @(posedge txclk);
    #1 rx_if.rx_WR_enabled = 1'b1;
    wait_drain(100);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL stall_done: got %0d required 1", done_cnt - d0); end
    tick(20);
  endtask

  task automatic test_holdoff();
    bit found = 0;
    int seen = 0;
    int d0 = done_cnt;
    timestamp_clock = 32'h0001_0203;
    push_pkt(2'b01, 16'd3, 16'd0, timestamp_clock);
    edge_pulse(1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge txclk);
      if (rx_if.rx_WR_done === 1'b1) begin
        found = 1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL holdoff_first: rx_WR_done not seen, required 1"); end
    for (int i = 1; i <= 16; i++) begin
      @(posedge txclk);
      #1;
      if (i == 2) begin
        tx_underrun[1] = 1'b1;
        push_pkt(2'b10, 16'd3, 16'd1, timestamp_clock);
      end
      if (i == 3) tx_underrun[1] = 1'b0;
      @(negedge txclk);
      if (rx_if.rx_WR === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL holdoff_quiet: %0d rx_WR cycles, required 0", seen); end
    wait_drain(100);
    total++; if (underrun_count[31:16] !== 16'd1) begin bad++; $display("FAIL holdoff_ch1: got %h required 0001", underrun_count[31:16]); end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL holdoff_done: got %0d required 2", done_cnt - d0); end
    tick(20);
  endtask

  task automatic test_saturation();
    bit busy_seen = 0;
    report_enable = 1'b0;
    @(posedge txclk);
    #1 force dut.g_chan[0].u_cnt.count = 16'hFFFD;
    @(posedge txclk);
    #1 release dut.g_chan[0].u_cnt.count;
    for (int i = 0; i < 4; i++) begin
      edge_pulse(1'b0);
      if (busy) busy_seen = 1;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge txclk);
      if (busy) busy_seen = 1;
    end
    total++; if (underrun_count[15:0] !== 16'hFFFF) begin bad++; $display("FAIL sat_count: got %h required ffff", underrun_count[15:0]); end
    total++; if (busy_seen) begin bad++; $display("FAIL sat_no_pkt: busy=1 seen, required 0"); end
    push_pkt(2'b01, 16'hFFFF, 16'd1, timestamp_clock);
    @(posedge txclk);
    #1 report_enable = 1'b1;
    wait_drain(100);
    tick(20);
  endtask

  task automatic test_clear_collision();
    int d0;
    report_enable = 1'b0;
    @(posedge txclk);
    #1 clear_status = 1'b1;
    @(posedge txclk);
    #1 clear_status = 1'b0;
    repeat (7) edge_pulse(1'b0);
    tick(3);
    total++; if (underrun_count !== {16'd0, 16'd7}) begin bad++; $display("FAIL clear_pre: got %h required 00000007", underrun_count); end
    @(posedge txclk);
    #1 tx_underrun[0] = 1'b1;
    @(posedge txclk);
    #1 tx_underrun[0] = 1'b0;
    clear_status = 1'b1;
    @(posedge txclk);
    #1 clear_status = 1'b0;
    @(negedge txclk);
    total++; if (underrun_count !== {16'd0, 16'd1}) begin bad++; $display("FAIL clear_collide: got %h required 00000001", underrun_count); end
    d0 = done_cnt;
    push_pkt(2'b01, 16'd1, 16'd0, timestamp_clock);
    @(posedge txclk);
    #1 report_enable = 1'b1;
    wait_drain(100);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL clear_report: got %0d packets required 1", done_cnt - d0); end
    tick(20);
  endtask

  task automatic test_reset_mid_packet();
    bit found = 0;
    int k = 0;
    int seen = 0;
    int d0;
    push_pkt(2'b10, 16'd1, 16'd1, timestamp_clock);
    edge_pulse(1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge txclk);
      if (rx_if.rx_WR === 1'b1) begin
        k++;
        if (k == TS_HI_POS) begin
          found = 1;
          break;
        end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach: %0d words seen, required %0d", k, TS_HI_POS); end
    @(posedge txclk);
    #2;
    total++; if (rx_if.rx_WR !== 1'b1) begin bad++; $display("FAIL rst_pre_wr: got %b required 1", rx_if.rx_WR); end
    reset = 1'b1;
    #1;
    total++; if (rx_if.rx_WR !== 1'b0 || rx_if.rx_WR_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_outputs: wr=%b done=%b busy=%b required 0 0 0", rx_if.rx_WR, rx_if.rx_WR_done, busy);
    end
    total++; if (underrun_count !== '0) begin bad++; $display("FAIL rst_counts: got %h required 0", underrun_count); end
    sb.delete();
    d0 = done_cnt;
    @(posedge txclk);
    #1 reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge txclk);
      if (rx_if.rx_WR === 1'b1) seen++;
    end
    total++; if (seen != 0 || done_cnt != d0) begin
      bad++; $display("FAIL rst_after: wr=%0d done=%0d required 0 0", seen, done_cnt - d0);
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_underrun = '0;
    clear_status = 1'b0;
    report_enable = 1'b1;
    timestamp_clock = 32'd0;
    rx_if.rx_WR_enabled = 1'b1;
    test_reset();
    test_single_edge();
    test_stall();
    test_holdoff();
    test_saturation();
    test_clear_collision();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_underrun_reporter.md
Name: tx_underrun_reporter

Overview:
- Sits directly downstream of the TX in-band buffer and consumes its per-channel tx_underrun flags.
- Counts underrun events per TX channel using 16-bit saturating counters.
- Emits a short in-band status packet into the RX in-band path over the same rx_databus / rx_WR / rx_WR_done handshake that the command reader uses.
- Runs entirely in the txclk domain and is rate-limited so reports cannot flood the RX path.

Parameters:
- NUM_CHAN, 2, number of TX channels monitored (1 or 2).
- HOLDOFF, 1024, minimum txclk cycles from the end of one report to the start of the next.
- PKT_TAG, 4'hA, tag placed in W0[15:12].

Ports:
- txclk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- tx_underrun  in  NUM_CHAN  per-channel underrun level from the TX buffer.
- clear_status  in  1  one-cycle pulse; clears counters and pending flags.
- report_enable  in  1  when low, counting continues but no packet is started.
- timestamp_clock  in  32  free-running TX timestamp.
- rx_WR_enabled  in  1  RX path may accept words.
- rx_databus  out  16  packet word.
- rx_WR  out  1  rx_databus valid this cycle.
- rx_WR_done  out  1  one-cycle end-of-packet pulse.
- underrun_count  out  16*NUM_CHAN  live counters; channel k occupies [16k+15:16k].
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async) values:
  - all counters 0, pending flags 0, holdoff counter 0;
  - rx_databus 0, rx_WR 0, rx_WR_done 0, busy 0;
  - FSM in IDLE.
- Edge detect:
  - tx_underrun is registered each cycle.
  - A rising edge on channel k increments count[k] (saturating at 16'hFFFF) and sets pend[k] on the following edge of txclk.
  - A level held high counts once.
- clear_status:
  - Zeroes all counters and pend.
  - A same-cycle rising edge wins for that channel: count=1, pend=1.
  - Does not abort a packet in flight.
- Start condition: FSM leaves IDLE when all of the following hold:
  - |pend is true;
  - report_enable is high;
  - rx_WR_enabled is high;
  - the holdoff counter is 0.
- Snapshot on leaving IDLE:
  - counts, pend and timestamp are latched into snapshot registers;
  - pend is cleared in the same cycle;
  - edges in that same cycle re-set pend.
- FSM states: IDLE -> W0 -> W1 -> [TS_LO -> TS_HI] -> CNT (one word per channel, ascending) -> DONE -> IDLE.
- Packet words:
  - W0 = {PKT_TAG, 10'b0, snap_pend (zero-extended to 2 bits)}.
  - W1 = number of words following W1 (4 with timestamp, 2 without, for NUM_CHAN=2).
  - TS_LO = ts[15:0], TS_HI = ts[31:16].
  - CNT words = snapshot counts.
- Handshake:
  - In each word state, rx_WR is high for exactly the cycles in which rx_WR_enabled is high; the FSM advances one word per such cycle.
  - If rx_WR_enabled drops mid-packet, rx_WR goes low, rx_databus holds its value, and the FSM stalls.
  - rx_WR_done is asserted for one cycle in DONE, with rx_WR low.
  - Padding to the full packet size is the RX buffer's job.
- Holdoff:
  - Loaded with HOLDOFF in DONE.
  - Decrements each cycle to 0.
  - Edges arriving during holdoff are counted and pended, then reported after holdoff expires.
- Latency: an edge in cycle n yields the earliest rx_WR at cycle n+3, given an idle FSM, enables high and holdoff 0.
- report_enable low mid-packet: the packet completes normally.
- underrun_count reflects the live counters, not the snapshots.

Optional Feature:
- TX_UNDERRUN_RPT_TIMESTAMP_EN:
  - Defined: TS_LO/TS_HI are emitted and W1 = 2+NUM_CHAN.
  - Undefined: the timestamp states and snapshot register are removed, W1 = NUM_CHAN, and the timestamp_clock port remains but is unused.

Decomposition:
- Package tx_underrun_rpt_pkg holds:
  - the FSM state enum;
  - PKT_TAG default;
  - word-count constants for the with/without-timestamp variants;
  - the counter saturation value 16'hFFFF.
- One natural sub-module, underrun_edge_counter: registered edge detect, saturating counter, pend flag and clear priority. It is instantiated NUM_CHAN times via generate.

Test Plan:
- Single edge:
  - Stimulus: one rising edge on ch0 with timestamp=32'h0001_0203 and TIMESTAMP_EN defined.
  - Response: words A001, 0004, 0203, 0001, 0001, 0000; then a one-cycle rx_WR_done; underrun_count[15:0]=1.
- Stall mid-packet:
  - Stimulus: drop rx_WR_enabled for 5 cycles after W1.
  - Response: rx_WR low for those 5 cycles, rx_databus stable, the remaining words resume in order, exactly one rx_WR_done.
- Holdoff:
  - Stimulus: HOLDOFF=16; ch1 edge 2 cycles after DONE.
  - Response: no rx_WR for 16 cycles after DONE, then W0=A002 and ch1 count=1.
- Saturation:
  - Stimulus: 65537 edges on ch0 with report_enable=0.
  - Response: count stays at FFFF and no packet is sent; raising report_enable then sends CNT0=FFFF.
- Clear collision:
  - Stimulus: clear_status asserted in the same cycle as a ch0 edge, with count previously 7.
  - Response: count=1, pend[0]=1, and a report follows.
- Async reset mid-packet:
  - Stimulus: assert reset during TS_HI.
  - Response: rx_WR, rx_WR_done and busy go low immediately; counters read 0; no rx_WR_done is emitted after release.
